// File: rtl/counter_cmd_sequencer.sv
// Push-button / DIP-switch front end for the 4-bit up/down counter.
// Synchronises and debounces raw inputs, then issues step and load strobes.
//
// Ports:
//   clk, rst_n     system clock, async active-low reset
//   btn_up         raw up button (async, active-high)
//   btn_down       raw down button (async, active-high)
//   btn_load       raw load button (async, active-high)
//   sw_value[3:0]  raw load value switches (async)
//   cnt_ena        1-cycle step strobe
//   cnt_up_down    step direction level, 1 = up
//   cnt_set        1-cycle load strobe
//   cnt_set_value  load value, held between loads
module counter_cmd_sequencer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 256,
    parameter int REPEAT_CYCLES   = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_load,
    input  logic [3:0] sw_value,
    output logic       cnt_ena,
    output logic       cnt_up_down,
    output logic       cnt_set,
    output logic [3:0] cnt_set_value
);

    localparam int TMAX =
        (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TW = $clog2(TMAX);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] REP_LD  = TW'(REPEAT_CYCLES - 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT,
        LOCK
    } state_t;

    // bit 0 up, 1 down, 2 load, 6:3 switches
    logic [6:0] raw_in;
    logic [6:0] sync_q [SYNC_STAGES];
    logic [6:0] synced;
    logic [2:0] btn_s;
    logic [3:0] sw_s;

    assign raw_in = {sw_value, btn_load, btn_down, btn_up};
    assign synced = sync_q[SYNC_STAGES-1];
    assign btn_s  = synced[2:0];
    assign sw_s   = synced[6:3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= raw_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    logic [2:0]    db;
    logic [2:0]    db_q;
    logic [DW-1:0] db_cnt [3];

    // Counter runs only while the synced level disagrees with db;
    // any agreeing cycle restarts the stability window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db   <= '0;
            db_q <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            db_q <= db;
            for (int i = 0; i < 3; i++) begin
                if (btn_s[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db[i]     <= btn_s[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    logic up_rise;
    logic down_rise;
    logic load_rise;

    assign up_rise   = db[0] & ~db_q[0];
    assign down_rise = db[1] & ~db_q[1];
    assign load_rise = db[2] & ~db_q[2];

    state_t        state;
    state_t        state_n;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_n;
    logic          dir_q;
    logic          dir_n;
    logic          pulse;
    logic          act;
    logic          opp;

    assign act = dir_q ? db[0] : db[1];
    assign opp = dir_q ? db[1] : db[0];

    always_comb begin
        state_n = state;
        timer_n = timer;
        dir_n   = dir_q;
        pulse   = 1'b0;
        unique case (state)
            IDLE: begin
                unique case (1'b1)
                    db[0] & db[1]: begin
                        state_n = LOCK;
                    end
                    up_rise & ~db[1]: begin
                        pulse   = 1'b1;
                        dir_n   = 1'b1;
                        state_n = HOLD;
                        timer_n = HOLD_LD;
                    end
                    down_rise & ~db[0]: begin
                        pulse   = 1'b1;
                        dir_n   = 1'b0;
                        state_n = HOLD;
                        timer_n = HOLD_LD;
                    end
                    default: ;
                endcase
            end
            HOLD, REPEAT: begin
                // Opposite button wins over release so a
                // swap of buttons never sneaks out a pulse.
                if (opp) begin
                    state_n = LOCK;
                end else if (!act) begin
                    state_n = IDLE;
                end else if (timer == '0) begin
                    pulse   = 1'b1;
                    state_n = REPEAT;
                    timer_n = REP_LD;
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            LOCK: begin
                if (!db[0] && !db[1]) begin
                    state_n = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            timer <= '0;
            dir_q <= 1'b1;
        end else begin
            state <= state_n;
            timer <= timer_n;
            dir_q <= dir_n;
        end
    end

    // A load strobe pre-empts a coincident step; the FSM
    // has already advanced as though the step went out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_ena       <= 1'b0;
            cnt_set       <= 1'b0;
            cnt_set_value <= 4'h0;
        end else begin
            cnt_ena <= pulse & ~load_rise;
            cnt_set <= load_rise;
            if (load_rise) begin
                cnt_set_value <= sw_s;
            end
        end
    end

    assign cnt_up_down = dir_q;

endmodule
